event_packer: RTL and testbench

- Parametrised next-generation event capture/readout block for the muon DAQ.
- On a trigger rising edge it snapshots an N_WORDS x WORD_W event bus and stamps it with a free-running timestamp. It then streams one optional header word plus the payload words into a downstream FIFO.
- It honours FIFO backpressure on every word and counts triggers lost while busy.
- It sits between the channel hit/TDC logic and the readout FIFO (wr_en/din/full interface).

---
 rtl/event_packer.sv | 127 ++++++++++++
 tb/tb_event_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/event_packer.sv
// Event capture/readout: snapshots the event bus on a trigger rise, stamps it,
// and streams an optional header plus the payload words into a FIFO under backpressure.
module event_packer #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned N_WORDS   = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned CNT_W     = 16,
  parameter bit          HEADER_EN = 1'b1
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           trigger,
  input  logic [N_WORDS-1:0][WORD_W-1:0] event_i,
  input  logic                           full_i,
  output logic                           wr_en_o,
  output logic [WORD_W-1:0]              din_o,
  output logic                           event_saved,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               dropped_o
);
  localparam int unsigned PTR_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned HDR_W = TS_W + 2 * CNT_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

  state_t                         state, state_nx;
  logic [PTR_W-1:0]               ptr, ptr_nx;
  logic                           trig_s1, trig_s2, trig_d, rise;
  logic [N_WORDS-1:0][WORD_W-1:0] ev_s1, ev_s2, snap;
  logic [TS_W-1:0]                ts, ts_snap;
  logic [CNT_W-1:0]               event_id, dropped, dropped_nx;
  logic [HDR_W-1:0]               hdr_raw;
  logic [WORD_W-1:0]              hdr_word;
  logic                           hdr_wr;

  // Event data runs through the same two stages as the trigger so the snapshot
  // lines up with the edge that produced the rise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
      ev_s1   <= '0;
      ev_s2   <= '0;
      ts      <= '0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      ev_s1   <= event_i;
      ev_s2   <= ev_s1;
      ts      <= ts + TS_W'(1);
    end
  end

  assign rise     = trig_s2 & ~trig_d;
  assign hdr_raw  = {dropped, event_id, ts_snap};
  assign hdr_word = WORD_W'(hdr_raw);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    wr_en_o  = 1'b0;
    din_o    = '0;
    hdr_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HEADER_EN ? HEADER : PAYLOAD;
          ptr_nx   = '0;
        end
      end
      HEADER: begin
        din_o   = hdr_word;
        wr_en_o = !full_i;
        if (!full_i) begin
          hdr_wr   = 1'b1;
          state_nx = PAYLOAD;
          ptr_nx   = '0;
        end
      end
      PAYLOAD: begin
        din_o   = snap[ptr];
        wr_en_o = !full_i;
        if (!full_i) begin
          if (ptr == LAST) state_nx = DONE;
          else             ptr_nx   = ptr + PTR_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Header write clears first, so a rise in the same cycle leaves a count of one.
  always_comb begin
    dropped_nx = hdr_wr ? '0 : dropped;
    if (rise && (state != IDLE) && (dropped_nx != '1))
      dropped_nx = dropped_nx + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ptr      <= '0;
      snap     <= '0;
      ts_snap  <= '0;
      event_id <= '0;
      dropped  <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      dropped <= dropped_nx;
      if (state == IDLE && rise) begin
        snap    <= ev_s2;
        ts_snap <= ts;
      end
      if (state == DONE) event_id <= event_id + CNT_W'(1);
    end
  end

  assign event_saved = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign dropped_o   = dropped;

endmodule

// File: tb/tb_event_packer.sv
// Self-checking bench for event_packer: default header build and a payload-only
// 4x32 build, randomized data/backpressure against a stream-level reference model.
module tb_event_packer;
  localparam int N  = 16;
  localparam int W  = 64;
  localparam int NB = 4;
  localparam int WB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   aresetn, trigger, full_i, wr_en_o, event_saved, busy_o;
  logic [N-1:0][W-1:0]    event_i;
  logic [W-1:0]           din_o;
  logic [15:0]            dropped_o;

  logic                   aresetn_b, trigger_b, full_b, wr_en_b, saved_b, busy_b;
  logic [NB-1:0][WB-1:0]  event_b;
  logic [WB-1:0]          din_b;
  logic [15:0]            dropped_b;

  event_packer #(.WORD_W(W), .N_WORDS(N), .TS_W(32), .CNT_W(16), .HEADER_EN(1'b1)) dut_a (
    .clk(clk), .aresetn(aresetn), .trigger(trigger), .event_i(event_i), .full_i(full_i),
    .wr_en_o(wr_en_o), .din_o(din_o), .event_saved(event_saved), .busy_o(busy_o),
    .dropped_o(dropped_o));

  event_packer #(.WORD_W(WB), .N_WORDS(NB), .TS_W(32), .CNT_W(16), .HEADER_EN(1'b0)) dut_b (
    .clk(clk), .aresetn(aresetn_b), .trigger(trigger_b), .event_i(event_b), .full_i(full_b),
    .wr_en_o(wr_en_b), .din_o(din_b), .event_saved(saved_b), .busy_o(busy_b),
    .dropped_o(dropped_b));

  // Clock edges since reset release: the value the free-running timestamp must hold.
  int unsigned cyc_a;
  always @(posedge clk or negedge aresetn)
    if (!aresetn) cyc_a <= 0;
    else          cyc_a <= cyc_a + 1;

  int checks = 0;
  int errors = 0;
  int unsigned exp_id = 0;
  int unsigned exp_drop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [N-1:0][W-1:0] data, input int trig_len,
                       input int full_at, input int full_len,
                       input int drop_at, input int n_drops,
                       input bit flip, input bit rand_full);
    logic [W-1:0] got[$];
    logic [31:0]  ts_exp;
    logic [63:0]  hdr_exp;
    int first_wr, last_wr, saved_cyc, saved_cnt, full_left, drop_c0;
    bit done, full_done, busy_seen, hdr_dchk;
    got.delete();
    ts_exp = '0; first_wr = -1; last_wr = -1; saved_cyc = -1; saved_cnt = 0;
    full_left = 0; drop_c0 = -1; done = 0; full_done = 0; busy_seen = 0; hdr_dchk = 0;
    event_i = data;
    for (int c = 0; c < 400 && !(done && c >= trig_len + 2); c++) begin
      @(negedge clk);
      trigger = (c < trig_len);
      if (drop_c0 >= 0 && c >= drop_c0 && c < drop_c0 + 4 * n_drops)
        trigger = ((c - drop_c0) % 4) < 2;
      if (rand_full) begin
        full_i = ($urandom_range(0, 3) == 0);
      end else begin
        if (!full_done && full_at >= 0 && got.size() == 1 + full_at) begin
          full_left = full_len;
          full_done = 1;
        end
        full_i = (full_left > 0);
        if (full_left > 0) full_left--;
      end
      if (flip && busy_seen) event_i = '1;
      #1;
      if (busy_o && !busy_seen) begin
        busy_seen = 1;
        ts_exp = 32'(cyc_a - 1);
      end
      if (full_i && got.size() > 0 && got.size() < N + 1) begin
        check("full_wr_en", wr_en_o, 0);
        check("full_hold", din_o, data[got.size() - 1]);
      end
      if (hdr_dchk) begin
        check("dropped_clr", dropped_o, 0);
        hdr_dchk = 0;
      end
      if (wr_en_o) begin
        if (got.size() == 0) first_wr = c;
        last_wr = c;
        got.push_back(din_o);
        if (got.size() == 1) hdr_dchk = 1;
        if (drop_at >= 0 && drop_c0 < 0 && got.size() == 1 + drop_at) drop_c0 = c + 1;
      end
      if (event_saved) begin
        saved_cnt++;
        saved_cyc = c;
        done = 1;
      end
    end
    @(negedge clk);
    trigger = 1'b0;
    full_i  = 1'b0;
    #1;
    check("timeout", done, 1);
    check("busy_after", busy_o, 0);
    check("saved_cnt", saved_cnt, 1);
    check("nwords", got.size(), N + 1);
    check("saved_latency", saved_cyc, last_wr + 1);
    if (!rand_full && full_len == 0) check("contiguous", last_wr - first_wr + 1, N + 1);
    hdr_exp = {16'h0, 16'(exp_drop), 16'(exp_id), ts_exp};
    if (got.size() > 0) check("header", got[0], hdr_exp);
    for (int k = 0; k < N; k++)
      if (k + 1 < got.size()) check($sformatf("payload%0d", k), got[k + 1], data[k]);
    check("dropped_end", dropped_o, n_drops);
    exp_drop = n_drops;
    exp_id++;
  endtask

  task automatic run_b(input logic [NB-1:0][WB-1:0] data, input bit do_reset);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    event_b = data;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      trigger_b = (c < 3);
      if (do_reset && n == 2) begin
        aresetn_b = 1'b0;
        #1;
        check("rst_wr_en", wr_en_b, 0);
        check("rst_din", din_b, 0);
        check("rst_busy", busy_b, 0);
        check("rst_saved", saved_b, 0);
        check("rst_dropped", dropped_b, 0);
        done = 1;
      end else begin
        #1;
        if (wr_en_b) begin
          if (n < NB) check($sformatf("b_word%0d", n), din_b, data[n]);
          n++;
        end
        if (saved_b) done = 1;
      end
    end
    check("b_done", done, 1);
    if (!do_reset) check("b_count", n, NB);
    trigger_b = 1'b0;
    if (do_reset) begin
      repeat (3) @(negedge clk);
      aresetn_b = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  logic [N-1:0][W-1:0]   base, rnd;
  logic [NB-1:0][WB-1:0] bd;

  initial begin
    aresetn = 1'b0; aresetn_b = 1'b0;
    trigger = 1'b0; trigger_b = 1'b0;
    full_i = 1'b0;  full_b = 1'b0;
    event_i = '0;   event_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_wr_en", wr_en_o, 0);
    check("reset_din", din_o, 0);
    check("reset_saved", event_saved, 0);
    check("reset_busy", busy_o, 0);
    check("reset_dropped", dropped_o, 0);
    aresetn = 1'b1; aresetn_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < N; k++) base[k] = 64'hA000 + 64'(k);
    run_a(base, 3, -1, 0, -1, 0, 1'b0, 1'b0);
    run_a(base, 3, 7, 5, -1, 0, 1'b0, 1'b0);
    run_a(base, 3, -1, 0, -1, 0, 1'b1, 1'b0);
    run_a(base, 3, -1, 0, 1, 3, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) rnd[k] = {$urandom, $urandom};
    run_a(rnd, 3, -1, 0, -1, 0, 1'b0, 1'b0);
    run_a(base, 100, -1, 0, -1, 0, 1'b0, 1'b0);
    run_a(base, 3, -1, 0, -1, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) rnd[k] = {$urandom, $urandom};
      run_a(rnd, $urandom_range(1, 6), -1, 0, -1, 0, 1'b0, 1'b1);
    end

    for (int k = 0; k < NB; k++) bd[k] = $urandom;
    run_b(bd, 1'b0);
    run_b(bd, 1'b1);
    for (int k = 0; k < NB; k++) bd[k] = $urandom;
    run_b(bd, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
